aeolus_sequencer: RTL

AEOLUS_SEQUENCER -- requirements
Module: aeolus_sequencer

---
 rtl/aeolus_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aeolus_sequencer.sv
// Control sequencer for a small accumulator CPU.
// Walks FETCH -> DECODE -> EXEC (-> MEM) per instruction and raises the
// datapath strobes for each phase. It supports free-running, single-step
// and halt operation, and keeps a saturating count of retired instructions.
// The strobes are decoded from the registered state and latched opcode.
// Only two things are taken straight from the inputs: the FETCH go decision,
// which reacts to run/step within its own cycle, and the conditional-jump
// flags, which are read live from the datapath.
module aeolus_sequencer #(
    parameter int COUNT_W = 8
) (
    input  logic               boardCLK,
    input  logic               reset,
    input  logic               run,
    input  logic               step_mode,
    input  logic               step_req,
    input  logic [3:0]         opcode,
    input  logic               zero_flag,
    input  logic               carry_flag,
    output logic               ir_load,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               acc_load,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               out_load,
    output logic               halted,
    output logic [1:0]         acc_src,
    output logic [2:0]         alu_op,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_HALT   = 3'b100
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_IN  = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JC  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [COUNT_W-1:0] RETIRED_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] RETIRED_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [3:0]         op_r;
    logic               pending_r;
    logic               step_d_r;
    logic [COUNT_W-1:0] retired_r;

    logic go_s;
    logic step_edge_s;
    logic retire_s;
    logic mem_op_s;

    // Instruction start, step-button edge, and retirement qualifiers.
    // Gating go with reset keeps the FETCH strobes low while reset is held.
    always_comb begin
        mem_op_s    = (op_r == OP_LD) || (op_r == OP_ST);
        go_s        = reset && run && (!step_mode || pending_r) && (state_r == ST_FETCH);
        step_edge_s = step_req && !step_d_r;
        if (state_r == ST_MEM) begin
            retire_s = 1'b1;
        end else if (state_r == ST_EXEC) begin
            retire_s = !mem_op_s;
        end else begin
            retire_s = 1'b0;
        end
    end

    // Datapath strobe decode for the current phase and latched opcode.
    always_comb begin
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        acc_load = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        out_load = 1'b0;
        halted   = 1'b0;
        acc_src  = 2'b00;
        alu_op   = 3'b000;
        case (state_r)
            ST_FETCH: begin
                ir_load = go_s;
                pc_inc  = go_s;
            end
            ST_EXEC: begin
                case (op_r)
                    OP_LDI: begin acc_load = 1'b1; acc_src = 2'b01; end
                    OP_ADD: begin acc_load = 1'b1; alu_op = 3'b000; end
                    OP_SUB: begin acc_load = 1'b1; alu_op = 3'b001; end
                    OP_AND: begin acc_load = 1'b1; alu_op = 3'b010; end
                    OP_OR:  begin acc_load = 1'b1; alu_op = 3'b011; end
                    OP_XOR: begin acc_load = 1'b1; alu_op = 3'b100; end
                    OP_LD:  mem_rd   = 1'b1;
                    OP_ST:  mem_wr   = 1'b1;
                    OP_OUT: out_load = 1'b1;
                    OP_IN:  begin acc_load = 1'b1; acc_src = 2'b11; end
                    OP_JMP: pc_load  = 1'b1;
                    OP_JZ:  pc_load  = zero_flag;
                    OP_JC:  pc_load  = carry_flag;
                    default: begin end
                endcase
            end
            ST_MEM: begin
                if (op_r == OP_LD) begin
                    acc_load = 1'b1;
                    acc_src  = 2'b10;
                end else begin
                    acc_load = 1'b0;
                end
            end
            ST_HALT: halted = 1'b1;
            default: begin end
        endcase
    end

    // Sequencer state, opcode latch, step pending flag and retire counter.
    always_ff @(posedge boardCLK or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_FETCH;
            op_r      <= 4'h0;
            pending_r <= 1'b0;
            step_d_r  <= 1'b0;
            retired_r <= {COUNT_W{1'b0}};
        end else begin
            step_d_r <= step_req;

            if (!step_mode) begin
                pending_r <= 1'b0;
            end else if (state_r == ST_HALT) begin
                pending_r <= pending_r;
            end else if (go_s) begin
                pending_r <= 1'b0;
            end else if (step_edge_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end

            if (retire_s && (retired_r != RETIRED_MAX)) begin
                retired_r <= retired_r + RETIRED_ONE;
            end else begin
                retired_r <= retired_r;
            end

            case (state_r)
                ST_FETCH:  state_r <= go_s ? ST_DECODE : ST_FETCH;
                ST_DECODE: begin
                    op_r    <= opcode;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (mem_op_s) begin
                        state_r <= ST_MEM;
                    end else if (op_r == OP_HLT) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_MEM:    state_r <= ST_FETCH;
                ST_HALT:   state_r <= ST_HALT;
                default:   state_r <= ST_FETCH;
            endcase
        end
    end

    assign state   = state_r;
    assign retired = retired_r;

endmodule
